// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths and types for the architectural register file
package core_pkg;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int ZERO_REG = 31;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_idx_t;

   localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

endpackage

// File: rtl/reg_word.sv
// rtl/reg_word.sv - one register word with asynchronous active-high clear and load enable
module reg_word
   import core_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load_en,
   input  word_t d,
   output word_t q
);

   word_t data_q;
   word_t data_d;

   always_comb begin
      data_d = data_q;
      if (load_en) begin
         data_d = d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x64 register file, XZR at index 31; REGFILE_BYPASS_EN adds write-through reads
module reg_file
   import core_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     RegWrite,
   input  reg_idx_t WriteReg,
   input  word_t    WriteData,
   input  reg_idx_t ReadReg1,
   input  reg_idx_t ReadReg2,
   output word_t    ReadData1,
   output word_t    ReadData2
);

   logic [NUM_REGS-1:0] en;
   word_t               regs [NUM_REGS];
   word_t               rd1;
   word_t               rd2;

   always_comb begin
      en = '0;
      if (RegWrite && !reset) begin
         en[WriteReg] = 1'b1;
      end
      en[ZERO_REG] = 1'b0;
   end

   // XZR has no storage; its slot is a constant zero.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
      if (i == ZERO_REG) begin : g_zero
         assign regs[i] = '0;
      end else begin : g_word
         reg_word u_word (
            .clk     (clk),
            .reset   (reset),
            .load_en (en[i]),
            .d       (WriteData),
            .q       (regs[i])
         );
      end
   end

   always_comb begin
      rd1 = regs[ReadReg1];
      rd2 = regs[ReadReg2];
`ifdef REGFILE_BYPASS_EN
      // Same-cycle forwarding of the writeback value resolves WB->ID hazards.
      if (RegWrite && (WriteReg == ReadReg1) && (ReadReg1 != ZERO_IDX)) begin
         rd1 = WriteData;
      end
      if (RegWrite && (WriteReg == ReadReg2) && (ReadReg2 != ZERO_IDX)) begin
         rd2 = WriteData;
      end
`endif
      if (reset) begin
         rd1 = '0;
         rd2 = '0;
      end
   end

   assign ReadData1 = rd1;
   assign ReadData2 = rd2;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file with a read scoreboard
`timescale 1ns/100ps
module tb_reg_file;
   import core_pkg::*;

   logic     clk = 1'b0;
   logic     reset;
   logic     RegWrite;
   reg_idx_t WriteReg;
   word_t    WriteData;
   reg_idx_t ReadReg1;
   reg_idx_t ReadReg2;
   word_t    ReadData1;
   word_t    ReadData2;

   reg_file dut (
      .clk       (clk),
      .reset     (reset),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2)
   );

   always #5 clk = ~clk;

   typedef struct {
      reg_idx_t a1;
      reg_idx_t a2;
      word_t    e1;
      word_t    e2;
   } sb_t;

   sb_t   sb_q[$];
   word_t model [NUM_REGS];
   int    tests_run = 0;
   int    fail_cnt  = 0;

   function automatic word_t model_read(input reg_idx_t a);
      if (reset || a == ZERO_IDX) return '0;
`ifdef REGFILE_BYPASS_EN
      if (RegWrite && WriteReg == a) return WriteData;
`endif
      return model[a];
   endfunction

   task automatic expect_read(input reg_idx_t a1, input reg_idx_t a2, input string tag);
      sb_t e;
      ReadReg1 = a1;
      ReadReg2 = a2;
      sb_q.push_back('{a1: a1, a2: a2, e1: model_read(a1), e2: model_read(a2)});
      #0.1;
      e = sb_q.pop_front();
      tests_run++;
      assert (ReadData1 === e.e1) else begin
         fail_cnt++;
         $error("FAIL %s port1 X%0d: observed %h expected %h", tag, e.a1, ReadData1, e.e1);
      end
      tests_run++;
      assert (ReadData2 === e.e2) else begin
         fail_cnt++;
         $error("FAIL %s port2 X%0d: observed %h expected %h", tag, e.a2, ReadData2, e.e2);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NUM_REGS; i++) begin
         expect_read(reg_idx_t'(i), reg_idx_t'(NUM_REGS - 1 - i), tag);
      end
   endtask

   task automatic do_write(input reg_idx_t a, input word_t d);
      @(negedge clk);
      RegWrite  = 1'b1;
      WriteReg  = a;
      WriteData = d;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      if (!reset && a != ZERO_IDX) model[a] = d;
   endtask

   initial begin
      reset     = 1'b1;
      RegWrite  = 1'b0;
      WriteReg  = '0;
      WriteData = '0;
      ReadReg1  = '0;
      ReadReg2  = '0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

      #2;
      check_all("reset_state");
      @(negedge clk);
      reset = 1'b0;

      // Test 1: preload A5 pattern then assert reset mid-cycle.
      for (int i = 0; i < NUM_REGS; i++) do_write(reg_idx_t'(i), 64'hA5A5_A5A5_A5A5_A5A5);
      check_all("preload");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      check_all("async_reset");

      // Writes during reset are ignored; first edge after release performs it.
      do_write(reg_idx_t'(3), 64'h3333_0000_3333_0000);
      check_all("write_in_reset");
      @(negedge clk);
      RegWrite  = 1'b1;
      WriteReg  = reg_idx_t'(3);
      WriteData = 64'h0BAD_F00D_0BAD_F00D;
      reset     = 1'b0;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      model[3] = 64'h0BAD_F00D_0BAD_F00D;
      expect_read(reg_idx_t'(3), reg_idx_t'(3), "release_write");

      // Test 2: write/readback.
      do_write(reg_idx_t'(5), 64'h0123_4567_89AB_CDEF);
      do_write(reg_idx_t'(30), 64'hFFFF_FFFF_FFFF_FFFF);
      expect_read(reg_idx_t'(5), reg_idx_t'(30), "readback");
      check_all("readback_others");

      // Test 3: zero register ignores writes.
      do_write(ZERO_IDX, 64'h0000_0000_DEAD_BEEF);
      expect_read(ZERO_IDX, ZERO_IDX, "xzr");
      check_all("xzr_others");

      // Test 4: same-cycle hazard.
      do_write(reg_idx_t'(7), 64'd1);
      @(negedge clk);
      RegWrite  = 1'b1;
      WriteReg  = reg_idx_t'(7);
      WriteData = 64'd2;
      expect_read(reg_idx_t'(7), reg_idx_t'(7), "hazard_pre");
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      model[7] = 64'd2;
      expect_read(reg_idx_t'(7), reg_idx_t'(7), "hazard_post");

      // Test 5: enable low sweep.
      for (int i = 0; i < NUM_REGS; i++) begin
         @(negedge clk);
         RegWrite  = 1'b0;
         WriteReg  = reg_idx_t'(i);
         WriteData = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
      check_all("enable_low");

      // Test 6: full sweep then reset.
      for (int i = 0; i < NUM_REGS - 1; i++) do_write(reg_idx_t'(i), word_t'(i) * 64'h1111);
      for (int i = 0; i < NUM_REGS - 1; i++) begin
         expect_read(reg_idx_t'(i), reg_idx_t'(NUM_REGS - 2 - i), "sweep");
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      check_all("sweep_reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
